// File: rtl/tag_lru_pkg.sv
// Shared types for the set-associative tag/LRU array.
// Entry parity exists only when TAG_LRU_ARRAY_PARITY_EN is defined.
package tag_lru_pkg;

  // Upper bounds on stored field widths. Narrower instances zero-extend into them.
  localparam int unsigned TAG_MAX_W = 32;
  localparam int unsigned AGE_MAX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  typedef struct packed {
`ifdef TAG_LRU_ARRAY_PARITY_EN
    logic                 parity;
`endif
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [AGE_MAX_W-1:0] age;
  } entry_t;

  // Empty entry whose age equals its way index.
  function automatic entry_t reset_entry(input int unsigned way);
    entry_t e;
    e     = '0;
    e.age = AGE_MAX_W'(way);
    return e;
  endfunction

endpackage

// File: rtl/tag_lru_age_update.sv
// Next-age vector for one set after the given way is touched: the touched way
// becomes MRU and every way younger than its old age ages by one.
module tag_lru_age_update #(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned AGE_W = 3,
  parameter int unsigned WAY_W = 1
) (
  input  logic [WAYS-1:0][AGE_W-1:0] ages,
  input  logic [WAY_W-1:0]           way,
  output logic [WAYS-1:0][AGE_W-1:0] next_ages_c
);

  logic [AGE_W-1:0] old_age;

  always_comb begin
    next_ages_c = ages;
    old_age     = ages[way];
    for (int w = 0; w < int'(WAYS); w++) begin
      if (WAY_W'(w) == way) begin
        next_ages_c[w] = '0;
      end else if (ages[w] < old_age) begin
        next_ages_c[w] = ages[w] + AGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/tag_lru_array.sv
// Set-associative tag array with per-set true-LRU ages and a one-set-per-cycle flush sweep.
// Optional entry parity and resp_perr port: define TAG_LRU_ARRAY_PARITY_EN.
module tag_lru_array
  import tag_lru_pkg::*;
#(
  parameter  int unsigned SETS  = 64,
  parameter  int unsigned WAYS  = 2,
  parameter  int unsigned TAG_W = 7,
  localparam int unsigned SET_W = $clog2(SETS),
  localparam int unsigned WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lookup_valid,
  input  logic [SET_W-1:0] lookup_set,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             lookup_ready,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [WAY_W-1:0] resp_way,
  input  logic             fill_valid,
  input  logic [SET_W-1:0] fill_set,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             flush_req,
  output logic             busy
`ifdef TAG_LRU_ARRAY_PARITY_EN
  ,
  output logic             resp_perr
`endif
);

  state_t           state;
  state_t           state_next;
  logic [SET_W-1:0] flush_ptr;
  entry_t           entries [SETS][WAYS];

  logic             sweep;
  logic             lk_acc;
  logic             fl_acc;
  logic             lk_hit;
  logic             lk_ok;
  logic [WAY_W-1:0] lk_hit_way;
  logic [WAY_W-1:0] lk_vic;
  logic [WAY_W-1:0] fl_vic;
  entry_t           lk_e;
`ifdef TAG_LRU_ARRAY_PARITY_EN
  logic             lk_perr;
`endif

  logic [WAYS-1:0][AGE_MAX_W-1:0] lk_ages;
  logic [WAYS-1:0][AGE_MAX_W-1:0] lk_ages_next;
  logic [WAYS-1:0][AGE_MAX_W-1:0] fl_ages;
  logic [WAYS-1:0][AGE_MAX_W-1:0] fl_ages_next;

  // Lowest invalid way, otherwise the LRU way.
  function automatic logic [WAY_W-1:0] victim_of(input logic [SET_W-1:0] s);
    logic [WAY_W-1:0] v;
    v = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (entries[s][w].age == AGE_MAX_W'(WAYS - 1)) v = WAY_W'(w);
    end
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!entries[s][w].valid) v = WAY_W'(w);
    end
    return v;
  endfunction

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM next state: flush requests are only taken from IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (flush_req) state_next = ST_FLUSH;
      ST_FLUSH: if (flush_ptr == SET_W'(SETS - 1)) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: a flush request drops any same-cycle lookup or fill.
  always_comb begin
    sweep  = 1'b0;
    lk_acc = 1'b0;
    fl_acc = 1'b0;
    if (state == ST_FLUSH) begin
      sweep = 1'b1;
    end else begin
      lk_acc = lookup_valid && !flush_req;
      fl_acc = fill_valid && !flush_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        flush_ptr <= '0;
    else if (sweep) flush_ptr <= flush_ptr + SET_W'(1);
  end

  // Tag compare against pre-update state; lowest matching way wins.
  always_comb begin
    lk_hit     = 1'b0;
    lk_hit_way = '0;
    lk_ok      = 1'b1;
    lk_e       = '0;
`ifdef TAG_LRU_ARRAY_PARITY_EN
    lk_perr    = 1'b0;
`endif
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      lk_e = entries[lookup_set][w];
`ifdef TAG_LRU_ARRAY_PARITY_EN
      lk_ok = !(^{lk_e.parity, lk_e.valid, lk_e.tag});
      if (lk_e.valid && !lk_ok) lk_perr = 1'b1;
`endif
      if (lk_e.valid && lk_ok && lk_e.tag == TAG_MAX_W'(lookup_tag)) begin
        lk_hit     = 1'b1;
        lk_hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    lk_vic = victim_of(lookup_set);
    fl_vic = victim_of(fill_set);
    for (int w = 0; w < int'(WAYS); w++) begin
      lk_ages[w] = entries[lookup_set][w].age;
      fl_ages[w] = entries[fill_set][w].age;
    end
  end

  tag_lru_age_update #(
    .WAYS  (WAYS),
    .AGE_W (AGE_MAX_W),
    .WAY_W (WAY_W)
  ) u_lk_age (
    .ages        (lk_ages),
    .way         (lk_hit_way),
    .next_ages_c (lk_ages_next)
  );

  tag_lru_age_update #(
    .WAYS  (WAYS),
    .AGE_W (AGE_MAX_W),
    .WAY_W (WAY_W)
  ) u_fl_age (
    .ages        (fl_ages),
    .way         (fl_vic),
    .next_ages_c (fl_ages_next)
  );

  // Entry storage: reset/flush restore, hit promotion, fill install.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          entries[s][w] <= reset_entry(w);
        end
      end
    end else if (sweep) begin
      for (int w = 0; w < int'(WAYS); w++) begin
        entries[flush_ptr][w] <= reset_entry(w);
      end
    end else begin
      // On a same-set collision the fill's promotion supersedes the hit's.
      if (lk_acc && lk_hit && !(fl_acc && fill_set == lookup_set)) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          entries[lookup_set][w].age <= lk_ages_next[w];
        end
      end
      if (fl_acc) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          entries[fill_set][w].age <= fl_ages_next[w];
        end
        entries[fill_set][fl_vic].valid <= 1'b1;
        entries[fill_set][fl_vic].tag   <= TAG_MAX_W'(fill_tag);
`ifdef TAG_LRU_ARRAY_PARITY_EN
        entries[fill_set][fl_vic].parity <= ^{1'b1, TAG_MAX_W'(fill_tag)};
`endif
      end
    end
  end

  // Registered response and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= 1'b0;
      lookup_ready <= 1'b1;
      resp_valid   <= 1'b0;
      resp_hit     <= 1'b0;
      resp_way     <= '0;
`ifdef TAG_LRU_ARRAY_PARITY_EN
      resp_perr    <= 1'b0;
`endif
    end else begin
      busy         <= (state_next == ST_FLUSH);
      lookup_ready <= (state_next != ST_FLUSH);
      resp_valid   <= lk_acc;
      resp_hit     <= lk_acc && lk_hit;
      resp_way     <= !lk_acc ? '0 : (lk_hit ? lk_hit_way : lk_vic);
`ifdef TAG_LRU_ARRAY_PARITY_EN
      resp_perr    <= lk_acc && lk_perr;
`endif
    end
  end

endmodule

// File: doc/tag_lru_array.md
TAG_LRU_ARRAY -- requirements
Module: tag_lru_array

Interface
REQ-001 Parameter SETS, default 64: number of sets; power of 2, 2..1024.
REQ-002 Parameter WAYS, default 2: associativity; power of 2, 2..8.
REQ-003 Parameter TAG_W, default 7: stored tag width in bits.
REQ-004 Derived widths: SET_W = log2(SETS); WAY_W = log2(WAYS).
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 lookup_valid  in  1  lookup request this cycle.
REQ-008 lookup_set  in  SET_W  set index of the lookup.
REQ-009 lookup_tag  in  TAG_W  tag to compare.
REQ-010 lookup_ready  out  1  high when a lookup is accepted; low while busy.
REQ-011 resp_valid  out  1  lookup result valid; one cycle after acceptance.
REQ-012 resp_hit  out  1  a valid way matched the tag.
REQ-013 resp_way  out  WAY_W  matching way on hit, else the victim way.
REQ-014 fill_valid  in  1  install fill_tag into the set's victim way.
REQ-015 fill_set  in  SET_W; fill_tag  in  TAG_W.
REQ-016 flush_req  in  1  invalidate all entries.
REQ-017 busy  out  1  flush sweep in progress.

Function
REQ-018 Storage per set and way: valid bit, TAG_W tag, WAY_W age; age 0 = MRU, age WAYS-1 = LRU.
REQ-019 Lookup: result is registered; resp_* are valid in cycle N+1 for a lookup accepted in cycle N; resp_valid is a one-cycle pulse.
REQ-020 Hit: exactly one valid way has tag == lookup_tag; that way becomes age 0, ways younger than its old age increment by 1, and the rest are unchanged.
REQ-021 Miss: no state change; resp_way = lowest-index invalid way if any, else the way with age WAYS-1.
REQ-022 Fill: writes the tag, sets valid and promotes the way to MRU, using the REQ-021 victim rule on current state; 1-cycle write, with no response output.
REQ-023 Same-cycle lookup and fill: both are accepted; the lookup compares pre-fill state; for the same set, the fill's LRU update wins and the lookup's hit update is dropped.
REQ-024 Ages within a set always form a permutation of 0..WAYS-1.
REQ-025 FSM states: IDLE and FLUSH. IDLE->FLUSH on flush_req; FLUSH clears valid bits and restores ages (way w = w) for one set per cycle, from 0 up to SETS-1; FLUSH->IDLE after set SETS-1.
REQ-026 busy = 1 in FLUSH; lookup_ready = ~busy; lookup_valid and fill_valid are ignored while busy; flush_req is ignored while busy.
REQ-027 flush_req in the same cycle as a lookup or fill: flush wins, and the others are dropped.
REQ-028 Flush of SETS sets takes exactly SETS cycles; lookup_ready rises in cycle SETS+1 after flush_req.

Reset
REQ-029 rst clears every valid bit, sets age of way w = w in every set, puts the FSM in IDLE, and clears resp_valid, resp_hit, resp_way, busy, and the pipeline register.
REQ-030 rst mid-flush aborts the sweep; the state equals the REQ-029 state one cycle later.
REQ-031 lookup_ready = 1 in the first cycle after rst deasserts.

Configuration
REQ-032 Macro TAG_LRU_ARRAY_PARITY_EN defined: each entry stores an even-parity bit over {valid, tag}; out port resp_perr (1 bit) pulses with resp_valid when any compared valid way fails parity; a failing way never reports a hit.
REQ-033 Macro TAG_LRU_ARRAY_PARITY_EN undefined: no parity storage and no resp_perr port.

Structure
REQ-034 Package tag_lru_pkg holds the FSM state enum and the entry struct typedef (valid, tag, age, optional parity).
REQ-035 One sub-module, tag_lru_age_update: combinational next-age vector given the current ages and the touched way.

Verification
REQ-036 Defaults; rst, then lookup set 5 tag 0x2A -> resp_valid at N+1, resp_hit=0, resp_way=0.
REQ-037 Fill set 5 tag 0x2A, then lookup -> hit=1, way=0; fill tag 0x11 -> way 1; lookup 0x2A again -> way 0 MRU, and the next fill of 0x33 evicts way 1.
REQ-038 WAYS=4: hit ways 2,0,3 in order -> ages {1,3,2,0} per way 0..3; miss victim = way 1.
REQ-039 flush_req with set 7 populated -> busy for 64 cycles, lookup_ready=0 meanwhile, and lookup after -> miss, way 0.
REQ-040 Same-cycle lookup and fill to set 3 (empty) -> lookup misses, fill lands in way 0; rst at flush cycle 20 -> state fully reset.
REQ-041 With parity enabled, force a flipped tag bit in set 2 way 0 -> resp_perr=1, resp_hit=0.
